// File: rtl/regfile_write_scheduler_if.sv
// Decode, writeback and register-file signals of the write scheduler.
// The scheduler takes the slave view; the driving side takes the master view.
interface regfile_write_scheduler_if;
   logic        issue_valid;
   logic [4:0]  issue_rs;
   logic [4:0]  issue_rt;
   logic [4:0]  issue_rd;
   logic        issue_stall;
   logic        alu_wb_valid;
   logic [4:0]  alu_wb_rd;
   logic [31:0] alu_wb_data;
   logic        mdu_wb_valid;
   logic [4:0]  mdu_wb_rd;
   logic [31:0] mdu_wb_data;
   logic        mdu_wb_ready;
   logic        rf_regwrite;
   logic [4:0]  rf_rd;
   logic [31:0] rf_writedata;
   logic [31:0] busy_vec;

   modport master (
      output issue_valid, issue_rs, issue_rt, issue_rd,
      output alu_wb_valid, alu_wb_rd, alu_wb_data,
      output mdu_wb_valid, mdu_wb_rd, mdu_wb_data,
      input  issue_stall, mdu_wb_ready,
      input  rf_regwrite, rf_rd, rf_writedata, busy_vec
   );

   modport slave (
      input  issue_valid, issue_rs, issue_rt, issue_rd,
      input  alu_wb_valid, alu_wb_rd, alu_wb_data,
      input  mdu_wb_valid, mdu_wb_rd, mdu_wb_data,
      output issue_stall, mdu_wb_ready,
      output rf_regwrite, rf_rd, rf_writedata, busy_vec
   );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Arbitrates the single register-file write port between ALU and MDU writeback,
// keeps the busy scoreboard and stalls decode on hazards or MDU starvation.
module regfile_write_scheduler #(
   parameter int MAX_WAIT = 4,
   parameter int WAIT_W   = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   regfile_write_scheduler_if.slave   bus
);

   logic [31:0]       busy_q, busy_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              rf_we_q, rf_we_d;
   logic [4:0]        rf_rd_q, rf_rd_d;
   logic [31:0]       rf_data_q, rf_data_d;

   logic        haz;
   logic        force_stall;
   logic        stall;
   logic        accept;
   logic        alu_gnt;
   logic        mdu_gnt;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_write;

   // Hazards look only at the registered scoreboard, so a same-cycle clear
   // releases the stalled instruction one cycle later.
   assign haz = bus.issue_valid &
                (((bus.issue_rs != 5'd0) & busy_q[bus.issue_rs]) |
                 ((bus.issue_rt != 5'd0) & busy_q[bus.issue_rt]) |
                 ((bus.issue_rd != 5'd0) & busy_q[bus.issue_rd]));

   assign force_stall = (wait_q == WAIT_W'(MAX_WAIT));
   assign stall       = haz | force_stall;
   assign accept      = bus.issue_valid & ~stall & (bus.issue_rd != 5'd0);

   assign alu_gnt  = bus.alu_wb_valid;
   assign mdu_gnt  = bus.mdu_wb_valid & ~bus.alu_wb_valid;
   assign wb_rd    = alu_gnt ? bus.alu_wb_rd   : bus.mdu_wb_rd;
   assign wb_data  = alu_gnt ? bus.alu_wb_data : bus.mdu_wb_data;
   assign wb_write = (alu_gnt | mdu_gnt) & (wb_rd != 5'd0);

   always_comb begin
      busy_d = busy_q;
      if (wb_write) busy_d[wb_rd] = 1'b0;
      // Set is applied after clear so it wins on the same register.
      if (accept) busy_d[bus.issue_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_comb begin
      rf_we_d   = 1'b0;
      rf_rd_d   = rf_rd_q;
      rf_data_d = rf_data_q;
      if (wb_write) begin
         rf_we_d   = 1'b1;
         rf_rd_d   = wb_rd;
         rf_data_d = wb_data;
      end
   end

   always_comb begin
      wait_d = '0;
      if (bus.mdu_wb_valid & bus.alu_wb_valid)
         wait_d = force_stall ? wait_q : wait_q + WAIT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q    <= '0;
         wait_q    <= '0;
         rf_we_q   <= 1'b0;
         rf_rd_q   <= '0;
         rf_data_q <= '0;
      end else begin
         busy_q    <= busy_d;
         wait_q    <= wait_d;
         rf_we_q   <= rf_we_d;
         rf_rd_q   <= rf_rd_d;
         rf_data_q <= rf_data_d;
      end
   end

   assign bus.issue_stall  = stall;
   assign bus.mdu_wb_ready = mdu_gnt;
   assign bus.rf_regwrite  = rf_we_q;
   assign bus.rf_rd        = rf_rd_q;
   assign bus.rf_writedata = rf_data_q;
   assign bus.busy_vec     = busy_q;

endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
- Shares the single register-file write port between the fixed-latency ALU writeback and the variable-latency multiply/divide unit (MDU).
- Keeps a 32-entry busy scoreboard and stalls decode on RAW/WAW hazards.
- Forces a decode stall when the MDU has waited too long for the port.
- Sits between decode/writeback and the register file; its write-port outputs drive the register file's regwrite/rd/writedata inputs directly.

Parameters:
- MAX_WAIT, 4: number of consecutive cycles a pending MDU writeback may be refused before issue is force-stalled.
- WAIT_W, 3: width of the starvation counter; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  decode presents an instruction this cycle
- issue_rs  in  5  source register 1
- issue_rt  in  5  source register 2
- issue_rd  in  5  destination register (0 = no write)
- issue_stall  out  1  decode must hold; the instruction is not accepted
- alu_wb_valid  in  1  ALU writeback; cannot be back-pressured
- alu_wb_rd  in  5  ALU destination
- alu_wb_data  in  32  ALU result
- mdu_wb_valid  in  1  MDU result pending
- mdu_wb_rd  in  5  MDU destination
- mdu_wb_data  in  32  MDU result
- mdu_wb_ready  out  1  MDU result accepted this cycle
- rf_regwrite  out  1  register-file write enable
- rf_rd  out  5  register-file write address
- rf_writedata  out  32  register-file write data
- busy_vec  out  32  scoreboard state; bit 0 is always 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - busy_vec = 0, rf_regwrite = 0, rf_rd = 0, rf_writedata = 0, wait counter = 0.
  - Any in-flight MDU handshake is abandoned; the MDU must re-present after reset.
- Hazard check (combinational):
  - haz = issue_valid & ((rs≠0 & busy[rs]) | (rt≠0 & busy[rt]) | (rd≠0 & busy[rd])).
  - issue_stall = haz | force_stall.
  - The check uses the registered busy state only; a clear occurring in the same cycle does not unblock issue until the next cycle.
- Issue accept: issue_valid & ~issue_stall & issue_rd≠0 sets busy[issue_rd] at the next edge.
- Port arbitration, fixed priority:
  - alu_wb_valid always wins.
  - mdu_wb_ready = mdu_wb_valid & ~alu_wb_valid.
  - The MDU transfer completes on a cycle where mdu_wb_valid & mdu_wb_ready are both high; the MDU holds rd/data stable while valid & ~ready.
- Write port:
  - Outputs are registered; one cycle of latency from the granted writeback to rf_* at the register file.
  - rf_regwrite = 1 only if the granted rd≠0.
  - If nothing is granted, or rd = 0: rf_regwrite = 0, and rf_rd/rf_writedata hold their previous values.
- Scoreboard clear:
  - The granted writeback's rd (≠0) clears busy[rd] at the same edge the rf_* registers load.
  - Set and clear of the same register in one cycle cannot occur, because issue to a busy rd stalls. If it happens anyway (the register is not busy and the ALU writes it), set wins.
- Starvation counter:
  - Increments each cycle mdu_wb_valid & alu_wb_valid; saturates at MAX_WAIT.
  - Resets to 0 on an MDU grant or when mdu_wb_valid = 0.
  - force_stall = (count == MAX_WAIT). Holding issue drains the ALU pipe, so alu_wb_valid drops within pipeline depth and the MDU is then granted.
- busy_vec[0] is hard-wired to 0. Writebacks to r0 are dropped but still complete the handshake.

Test Plan:
- Reset mid-operation: busy_vec = 0x0000_0010 with an MDU pending, pulse rst_n low -> busy_vec = 0, rf_regwrite = 0 immediately (asynchronously); after release, mdu_wb_ready follows mdu_wb_valid.
- RAW stall: issue rd=5 at cycle 0; at cycle 1 issue rs=5 -> issue_stall = 1. ALU writes rd=5 at cycle 3 -> rf_regwrite = 1, rf_rd = 5 at cycle 4; the issue is accepted at cycle 4, not cycle 3.
- Collision: alu_wb (rd=3, 0xAAAA_0000) and mdu_wb (rd=7, 0x1234_5678) valid together -> ALU written first, mdu_wb_ready = 0. Next cycle the ALU is idle -> rd=7 written with 0x1234_5678, busy[7] cleared.
- Starvation: MAX_WAIT = 4, alu_wb_valid held high with the MDU pending -> issue_stall = 1 from the 5th cycle. Drop alu_wb_valid -> MDU granted, counter = 0, issue_stall falls.
- r0 handling: issue rd=0 and MDU writeback rd=0 -> busy_vec unchanged, rf_regwrite = 0, mdu_wb_ready = 1.
- WAW: issue rd=9 twice back-to-back -> the second instruction is stalled until busy[9] clears.
